// File: rtl/inv_mixcol_seq.sv
// Time-multiplexed AES InvMixColumns: COLS_PER_CYC shared column units sweep one buffered state.
// Optional feature: define INV_MIXCOL_BYPASS_EN to add bypass_i (pass the state through unmixed).

module inv_aes_mixw (
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] m11 [4];
  logic [7:0] m13 [4];
  logic [7:0] m14 [4];

  // Every inverse coefficient is built from the doubling chain x2/x4/x8 of each byte.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2[i]  = xt(a[i]);
      x4[i]  = xt(x2[i]);
      x8[i]  = xt(x4[i]);
      m9[i]  = x8[i] ^ a[i];
      m11[i] = x8[i] ^ x2[i] ^ a[i];
      m13[i] = x8[i] ^ x4[i] ^ a[i];
      m14[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  assign mixed[31:24] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
  assign mixed[23:16] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
  assign mixed[15:8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
  assign mixed[7:0]   = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];

endmodule

module inv_mixcol_seq #(
  parameter int COLS_PER_CYC = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_state_i,
`ifdef INV_MIXCOL_BYPASS_EN
  input  logic         bypass_i,
`endif
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_state_o,
  output logic         busy_o
);

  if (COLS_PER_CYC != 1 && COLS_PER_CYC != 2 && COLS_PER_CYC != 4) begin : g_bad_param
    $error("inv_mixcol_seq: COLS_PER_CYC must be 1, 2 or 4");
  end

  // With four units the step wraps to 0, so col_cnt stays 0 and the first PROC cycle is the last.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYC);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYC);

  typedef enum logic [1:0] {IDLE, PROC, DONE} fsm_t;

  fsm_t         fsm, fsm_next;
  logic [1:0]   col_cnt, col_next;
  logic [127:0] state_reg, state_next, mixed_state;
  logic         load_go_done;

  logic [1:0]  unit_idx [COLS_PER_CYC];
  logic [31:0] unit_in  [COLS_PER_CYC];
  logic [31:0] unit_out [COLS_PER_CYC];

  always_comb begin
    for (int k = 0; k < COLS_PER_CYC; k++) begin
      unit_idx[k] = col_cnt + 2'(k);
      unit_in[k]  = state_reg[127-32*int'(unit_idx[k]) -: 32];
    end
  end

  for (genvar k = 0; k < COLS_PER_CYC; k++) begin : g_unit
    inv_aes_mixw u_mixw (
      .col   (unit_in[k]),
      .mixed (unit_out[k])
    );
  end

  always_comb begin
    mixed_state = state_reg;
    for (int k = 0; k < COLS_PER_CYC; k++) begin
      mixed_state[127-32*int'(unit_idx[k]) -: 32] = unit_out[k];
    end
  end

`ifdef INV_MIXCOL_BYPASS_EN
  assign load_go_done = bypass_i;
`else
  assign load_go_done = 1'b0;
`endif

  always_comb begin
    fsm_next    = fsm;
    col_next    = col_cnt;
    state_next  = state_reg;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_next = in_state_i;
          col_next   = 2'd0;
          fsm_next   = load_go_done ? DONE : PROC;
        end
      end
      PROC: begin
        state_next = mixed_state;
        col_next   = col_cnt + STEP;
        if (col_cnt == LAST) fsm_next = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        if (out_ready_i) begin
          if (in_valid_i) begin
            state_next = in_state_i;
            col_next   = 2'd0;
            fsm_next   = load_go_done ? DONE : PROC;
          end else begin
            fsm_next = IDLE;
          end
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm       <= IDLE;
      col_cnt   <= 2'd0;
      state_reg <= '0;
    end else begin
      fsm       <= fsm_next;
      col_cnt   <= col_next;
      state_reg <= state_next;
    end
  end

  assign out_state_o = state_reg;
  assign busy_o      = (fsm != IDLE);

endmodule
